byte_triplet_packer: RTL

//  Upstream feeder for top: packs a byte stream (valid/ready, last-marked) into
//  3-byte groups and drives top's a_top/b_top/c_top/d_top inputs.

---
 rtl/byte_triplet_packer_if.sv | 21 ++
 rtl/byte_triplet_packer.sv | 63 ++++++
 2 files changed

// File: rtl/byte_triplet_packer_if.sv
// byte_triplet_packer_if: byte stream in, padded 3-byte group out
interface byte_triplet_packer_if;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic            out_flag;
  logic [1:0]      out_nbytes;
  logic [0:2][7:0] out_pkd;
  logic [7:0]      out_unp [0:2];
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_flag, out_nbytes, out_pkd, out_unp
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_flag, out_nbytes, out_pkd, out_unp
  );
endinterface

// File: rtl/byte_triplet_packer.sv
// byte_triplet_packer: packs a valid/ready byte stream into padded 3-byte groups,
// with an optional idle timeout that flushes a partial group.
module byte_triplet_packer #(
  parameter logic [7:0] PAD_BYTE  = 8'h00,
  parameter int         FLUSH_CYC = 0,
  parameter int         CNT_W     = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  byte_triplet_packer_if.slave bus
);
  localparam logic [CNT_W-1:0] FC = CNT_W'(FLUSH_CYC);
  logic [7:0]       r_buf [0:2];
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_flag;
  logic [1:0]       r_n;
  logic [0:2][7:0]  r_pkd;
  logic             w_acc;
  logic             w_close;
  logic             w_flush;
  logic             w_load;
  logic [0:2][7:0]  w_grp;
  assign bus.in_ready   = rst_n & (!r_valid | bus.out_ready);
  assign w_acc          = bus.in_valid & bus.in_ready;
  assign w_close        = w_acc & ((r_idx == 2'd2) | bus.in_last);
  // an accepted byte wins over a flush that would fire in the same cycle
  assign w_flush        = (FLUSH_CYC > 0) && (r_idx != 2'd0) && (r_cnt == FC) && !w_acc
                          && (!r_valid || bus.out_ready);
  assign w_load         = w_close | w_flush;
  assign bus.out_valid  = r_valid;
  assign bus.out_flag   = r_flag;
  assign bus.out_nbytes = r_n;
  assign bus.out_pkd    = r_pkd;
  assign bus.out_unp    = '{r_pkd[0], r_pkd[1], r_pkd[2]};
  always_comb begin
    w_grp = '0;
    for (int k = 0; k < 3; k++)
      w_grp[k] = (2'(k) < r_idx) ? r_buf[k] : ((2'(k) == r_idx) && w_close) ? bus.in_data : PAD_BYTE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '{default: '0};
      r_idx   <= 2'd0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_flag  <= 1'b0;
      r_n     <= 2'd0;
      r_pkd   <= '0;
    end else begin
      if (w_acc) r_buf[r_idx] <= bus.in_data;
      r_idx   <= w_load ? 2'd0 : w_acc ? r_idx + 2'd1 : r_idx;
      r_cnt   <= (w_acc || r_idx == 2'd0 || w_flush) ? '0 : (r_cnt == FC) ? r_cnt : r_cnt + CNT_W'(1);
      r_valid <= w_load | (r_valid & !bus.out_ready);
      if (w_load) begin
        r_pkd  <= w_grp;
        r_n    <= w_close ? r_idx : r_idx - 2'd1;
        r_flag <= w_close & bus.in_last;
      end
    end
  end
endmodule
